// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-port data-memory arbiter and its requesters.
package dmem_arbiter_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Word-address regions that requesters agree on when sharing dmem.
    localparam logic [ADDR_W_DEF-1:0] DMEM_BASE_DATA  = 11'h000;
    localparam logic [ADDR_W_DEF-1:0] DMEM_BASE_STACK = 11'h600;
    localparam logic [ADDR_W_DEF-1:0] DMEM_BASE_XFER  = 11'h700;

    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way grant selector: a live lock owner wins, otherwise round-robin on prio.
module dmem_rr_pick
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       owner_valid,
    input  logic       owner_id,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (owner_valid && req[owner_id]) begin
            gnt[owner_id] = 1'b1;
        end else if (req == 2'b11) begin
            gnt[prio] = 1'b1;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one dmem between the CPU port and an auxiliary master, with
// round-robin arbitration, burst locking and one-cycle registered read data.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              r0_req,
    input  logic              r0_we,
    input  logic              r0_lock,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_gnt,
    output logic              r0_rvalid,
    output logic [DATA_W-1:0] r0_rdata,

    input  logic              r1_req,
    input  logic              r1_we,
    input  logic              r1_lock,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_gnt,
    output logic              r1_rvalid,
    output logic [DATA_W-1:0] r1_rdata,

    output logic              DM_cs,
    output logic              DM_R,
    output logic              DM_W,
    output logic [ADDR_W-1:0] DM_addr,
    output logic [DATA_W-1:0] DM_data_in,
    input  logic [DATA_W-1:0] DM_data_out
);

    logic              prio_q, prio_d;
    logic              owner_valid_q, owner_valid_d;
    logic              owner_id_q, owner_id_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];

    logic [1:0] req;
    logic [1:0] we;
    logic [1:0] pick_gnt;
    logic [1:0] gnt;
    logic       sel_id;
    logic       sel_lock;

    assign req = {r1_req, r0_req};
    assign we  = {r1_we, r0_we};

    dmem_rr_pick u_pick (
        .req         (req),
        .prio        (prio_q),
        .owner_valid (owner_valid_q),
        .owner_id    (owner_id_q),
        .gnt         (pick_gnt)
    );

    // Grants are combinational, so they must be masked while reset is held.
    assign gnt      = rst ? 2'b00 : pick_gnt;
    assign sel_id   = gnt[1];
    assign sel_lock = gnt[1] ? r1_lock : r0_lock;

    assign r0_gnt    = gnt[0];
    assign r1_gnt    = gnt[1];
    assign r0_rvalid = rvalid_q[0];
    assign r1_rvalid = rvalid_q[1];
    assign r0_rdata  = rdata_q[0];
    assign r1_rdata  = rdata_q[1];

    always_comb begin
        DM_cs      = |gnt;
        DM_R       = 1'b0;
        DM_W       = 1'b0;
        DM_addr    = '0;
        DM_data_in = '0;
        if (gnt[0]) begin
            DM_W       = r0_we;
            DM_R       = ~r0_we;
            DM_addr    = r0_addr;
            DM_data_in = r0_wdata;
        end else if (gnt[1]) begin
            DM_W       = r1_we;
            DM_R       = ~r1_we;
            DM_addr    = r1_addr;
            DM_data_in = r1_wdata;
        end
    end

    // An idle cycle means the owner (if any) dropped req, so ownership ends.
    always_comb begin
        prio_d        = prio_q;
        owner_valid_d = 1'b0;
        owner_id_d    = owner_id_q;
        if (|gnt) begin
            if (sel_lock) begin
                owner_valid_d = 1'b1;
                owner_id_d    = sel_id;
            end else begin
                prio_d = other_port(sel_id);
            end
        end
        for (int p = 0; p < 2; p++) begin
            rvalid_d[p] = gnt[p] & ~we[p];
            rdata_d[p]  = rvalid_d[p] ? DM_data_out : rdata_q[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q        <= PORT_CPU;
            owner_valid_q <= 1'b0;
            owner_id_q    <= PORT_CPU;
            rvalid_q      <= 2'b00;
            rdata_q[0]    <= '0;
            rdata_q[1]    <= '0;
        end else begin
            prio_q        <= prio_d;
            owner_valid_q <= owner_valid_d;
            owner_id_q    <= owner_id_d;
            rvalid_q      <= rvalid_d;
            rdata_q[0]    <= rdata_d[0];
            rdata_q[1]    <= rdata_d[1];
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed vector bench for dmem_arbiter with a behavioural dmem attached.
module tb_dmem_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;
    localparam int NV = 24;

    logic          clk;
    logic          rst;
    logic          r0_req, r0_we, r0_lock;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_gnt, r0_rvalid;
    logic [DW-1:0] r0_rdata;
    logic          r1_req, r1_we, r1_lock;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_gnt, r1_rvalid;
    logic [DW-1:0] r1_rdata;
    logic          DM_cs, DM_R, DM_W;
    logic [AW-1:0] DM_addr;
    logic [DW-1:0] DM_data_in;
    logic [DW-1:0] DM_data_out;

    int checks   = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .r0_req      (r0_req),
        .r0_we       (r0_we),
        .r0_lock     (r0_lock),
        .r0_addr     (r0_addr),
        .r0_wdata    (r0_wdata),
        .r0_gnt      (r0_gnt),
        .r0_rvalid   (r0_rvalid),
        .r0_rdata    (r0_rdata),
        .r1_req      (r1_req),
        .r1_we       (r1_we),
        .r1_lock     (r1_lock),
        .r1_addr     (r1_addr),
        .r1_wdata    (r1_wdata),
        .r1_gnt      (r1_gnt),
        .r1_rvalid   (r1_rvalid),
        .r1_rdata    (r1_rdata),
        .DM_cs       (DM_cs),
        .DM_R        (DM_R),
        .DM_W        (DM_W),
        .DM_addr     (DM_addr),
        .DM_data_in  (DM_data_in),
        .DM_data_out (DM_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dmem: untouched words read as A000_0000+addr, except word 5.
    logic [DW-1:0] mem       [0:2047];
    bit            mem_valid [0:2047];

    function automatic logic [DW-1:0] dflt_word(input logic [AW-1:0] a);
        if (a == 11'd5) return 32'hDEADBEEF;
        return 32'hA000_0000 | {21'd0, a};
    endfunction

    assign DM_data_out = mem_valid[DM_addr] ? mem[DM_addr] : dflt_word(DM_addr);

    always @(posedge clk) begin
        if (DM_cs && DM_W) begin
            mem[DM_addr]       <= DM_data_in;
            mem_valid[DM_addr] <= 1'b1;
        end
    end

    typedef struct {
        logic          r0_req, r0_we, r0_lock;
        logic [AW-1:0] r0_addr;
        logic [DW-1:0] r0_wdata;
        logic          r1_req, r1_we, r1_lock;
        logic [AW-1:0] r1_addr;
        logic [DW-1:0] r1_wdata;
        logic [1:0]    gnt;
        logic          dmw;
        logic [AW-1:0] dmaddr;
        logic [1:0]    rv;
        logic [DW-1:0] rd0, rd1;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input int q0, input int w0, input int l0, input int a0, input int d0,
                                input int q1, input int w1, input int l1, input int a1, input int d1,
                                input int g, input int dw, input int da, input int rv,
                                input int rd0, input int rd1);
        vec_t v;
        v.r0_req = q0[0]; v.r0_we = w0[0]; v.r0_lock = l0[0];
        v.r0_addr = a0[AW-1:0]; v.r0_wdata = d0;
        v.r1_req = q1[0]; v.r1_we = w1[0]; v.r1_lock = l1[0];
        v.r1_addr = a1[AW-1:0]; v.r1_wdata = d1;
        v.gnt = g[1:0]; v.dmw = dw[0]; v.dmaddr = da[AW-1:0]; v.rv = rv[1:0];
        v.rd0 = rd0; v.rd1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        r0_req = v.r0_req; r0_we = v.r0_we; r0_lock = v.r0_lock;
        r0_addr = v.r0_addr; r0_wdata = v.r0_wdata;
        r1_req = v.r1_req; r1_we = v.r1_we; r1_lock = v.r1_lock;
        r1_addr = v.r1_addr; r1_wdata = v.r1_wdata;
    endtask

    task automatic set_idle();
        r0_req = 0; r0_we = 0; r0_lock = 0; r0_addr = '0; r0_wdata = '0;
        r1_req = 0; r1_we = 0; r1_lock = 0; r1_addr = '0; r1_wdata = '0;
    endtask

    initial begin
        vec_t e;
        logic [DW-1:0] exp_din;
        rst = 1'b1;
        set_idle();
        //              r0: req we lk addr data        r1: req we lk addr data      gnt w addr rv  rd0           rd1
        vecs[0]  = mk(1,1,0,3,32'h11,         1,0,0,3,0,             1,1,3, 0, 0,            0);
        vecs[1]  = mk(0,0,0,0,0,              1,0,0,3,0,             2,0,3, 0, 0,            0);
        vecs[2]  = mk(0,0,0,0,0,              0,0,0,0,0,             0,0,0, 2, 0,            32'h11);
        vecs[3]  = mk(1,0,0,5,0,              0,0,0,0,0,             1,0,5, 0, 0,            32'h11);
        vecs[4]  = mk(0,0,0,0,0,              0,0,0,0,0,             0,0,0, 1, 32'hDEADBEEF, 32'h11);
        vecs[5]  = mk(0,0,0,0,0,              1,0,0,7,0,             2,0,7, 0, 32'hDEADBEEF, 32'h11);
        vecs[6]  = mk(1,0,0,1,0,              1,0,0,2,0,             1,0,1, 2, 32'hDEADBEEF, 32'hA0000007);
        vecs[7]  = mk(1,0,0,1,0,              1,0,0,2,0,             2,0,2, 1, 32'hA0000001, 32'hA0000007);
        vecs[8]  = mk(1,0,0,1,0,              1,0,0,2,0,             1,0,1, 2, 32'hA0000001, 32'hA0000002);
        vecs[9]  = mk(1,0,0,1,0,              1,0,0,2,0,             2,0,2, 1, 32'hA0000001, 32'hA0000002);
        vecs[10] = mk(1,0,0,1,0,              1,0,0,2,0,             1,0,1, 2, 32'hA0000001, 32'hA0000002);
        vecs[11] = mk(1,0,0,1,0,              1,0,0,2,0,             2,0,2, 1, 32'hA0000001, 32'hA0000002);
        vecs[12] = mk(1,0,0,4,0,              0,0,0,0,0,             1,0,4, 2, 32'hA0000001, 32'hA0000002);
        vecs[13] = mk(1,0,0,8,0,              1,1,1,8,32'hB0,        2,1,8, 1, 32'hA0000004, 32'hA0000002);
        vecs[14] = mk(1,0,0,8,0,              1,1,1,9,32'hB1,        2,1,9, 0, 32'hA0000004, 32'hA0000002);
        vecs[15] = mk(1,0,0,8,0,              1,1,1,10,32'hB2,       2,1,10,0, 32'hA0000004, 32'hA0000002);
        vecs[16] = mk(1,0,0,8,0,              1,1,0,11,32'hB3,       2,1,11,0, 32'hA0000004, 32'hA0000002);
        vecs[17] = mk(1,0,0,8,0,              0,0,0,0,0,             1,0,8, 0, 32'hA0000004, 32'hA0000002);
        vecs[18] = mk(0,0,0,0,0,              0,0,0,0,0,             0,0,0, 1, 32'hB0,       32'hA0000002);
        vecs[19] = mk(1,0,0,12,0,             1,1,1,12,32'hC0,       2,1,12,0, 32'hB0,       32'hA0000002);
        vecs[20] = mk(1,0,0,12,0,             1,1,1,13,32'hC1,       2,1,13,0, 32'hB0,       32'hA0000002);
        vecs[21] = mk(1,0,0,12,0,             0,1,1,13,32'hC1,       1,0,12,0, 32'hB0,       32'hA0000002);
        vecs[22] = mk(0,0,0,0,0,              0,0,0,0,0,             0,0,0, 1, 32'hC0,       32'hA0000002);
        vecs[23] = mk(1,0,0,13,0,             1,0,0,5,0,             2,0,5, 0, 32'hC0,       32'hA0000002);

        // Requests present during reset must not be granted.
        #2;
        r0_req = 1; r0_we = 1; r1_req = 1;
        #5;
        chk("reset gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
        chk("reset cs", 32'(DM_cs), 32'd0);
        chk("reset w", 32'(DM_W), 32'd0);
        chk("reset r", 32'(DM_R), 32'd0);
        chk("reset rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        chk("reset rdata0", r0_rdata, 32'd0);
        chk("reset rdata1", r1_rdata, 32'd0);
        $display("reset: gnt=%b rvalid=%b", {r1_gnt, r0_gnt}, {r1_rvalid, r0_rvalid});
        set_idle();
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            e = vecs[i];
            drive(e);
            @(negedge clk);
            exp_din = e.gnt[0] ? e.r0_wdata : (e.gnt[1] ? e.r1_wdata : '0);
            chk($sformatf("v%0d gnt", i), 32'({r1_gnt, r0_gnt}), 32'(e.gnt));
            chk($sformatf("v%0d cs", i), 32'(DM_cs), 32'(|e.gnt));
            chk($sformatf("v%0d w", i), 32'(DM_W), 32'(e.dmw));
            chk($sformatf("v%0d r", i), 32'(DM_R), 32'((|e.gnt) & ~e.dmw));
            chk($sformatf("v%0d addr", i), 32'(DM_addr), 32'(e.dmaddr));
            chk($sformatf("v%0d din", i), DM_data_in, exp_din);
            chk($sformatf("v%0d rvalid", i), 32'({r1_rvalid, r0_rvalid}), 32'(e.rv));
            chk($sformatf("v%0d rdata0", i), r0_rdata, e.rd0);
            chk($sformatf("v%0d rdata1", i), r1_rdata, e.rd1);
            $display("v%0d: gnt=%b cs=%b r=%b w=%b addr=%0d rvalid=%b rdata0=%h rdata1=%h",
                     i, {r1_gnt, r0_gnt}, DM_cs, DM_R, DM_W, DM_addr,
                     {r1_rvalid, r0_rvalid}, r0_rdata, r1_rdata);
        end

        // r1 takes a lock while its earlier read result is pending, then reset hits mid-cycle.
        @(posedge clk);
        #1;
        set_idle();
        r1_req = 1; r1_we = 1; r1_lock = 1; r1_addr = 11'd15; r1_wdata = 32'hE0;
        @(negedge clk);
        chk("pre-rst gnt", 32'({r1_gnt, r0_gnt}), 32'd2);
        chk("pre-rst rvalid1", 32'(r1_rvalid), 32'd1);
        chk("pre-rst rdata1", r1_rdata, 32'hDEADBEEF);
        #2;
        rst = 1'b1;
        #1;
        chk("async gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
        chk("async cs", 32'(DM_cs), 32'd0);
        chk("async w", 32'(DM_W), 32'd0);
        chk("async r", 32'(DM_R), 32'd0);
        chk("async addr", 32'(DM_addr), 32'd0);
        chk("async rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd0);
        chk("async rdata1", r1_rdata, 32'd0);
        $display("async reset: gnt=%b cs=%b rvalid=%b", {r1_gnt, r0_gnt}, DM_cs, {r1_rvalid, r0_rvalid});
        @(posedge clk);
        #1;
        set_idle();
        r0_req = 1; r0_addr = 11'd13;
        r1_req = 1; r1_addr = 11'd5;
        chk("in-rst contention gnt", 32'({r1_gnt, r0_gnt}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post-rst first gnt", 32'({r1_gnt, r0_gnt}), 32'd1);
        chk("post-rst addr", 32'(DM_addr), 32'd13);
        $display("post-rst c0: gnt=%b addr=%0d", {r1_gnt, r0_gnt}, DM_addr);
        @(posedge clk);
        #1;
        chk("post-rst second gnt", 32'({r1_gnt, r0_gnt}), 32'd2);
        chk("post-rst rvalid0", 32'(r0_rvalid), 32'd1);
        chk("post-rst rdata0", r0_rdata, 32'hC1);
        $display("post-rst c1: gnt=%b rvalid0=%b rdata0=%h", {r1_gnt, r0_gnt}, r0_rvalid, r0_rdata);
        @(posedge clk);
        #1;
        set_idle();
        chk("post-rst rvalid", 32'({r1_rvalid, r0_rvalid}), 32'd2);
        chk("post-rst rdata1", r1_rdata, 32'hDEADBEEF);
        $display("post-rst c2: rvalid=%b rdata1=%h", {r1_rvalid, r0_rvalid}, r1_rdata);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
